// File: rtl/nbbpu_pkg.sv
// nbbpu_pkg: opcodes, instruction field positions and legality check shared by the ALU front end
package nbbpu_pkg;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_CMP = 4'd7;
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RX_HI  = 11;
    localparam int RX_LO  = 8;
    localparam int RY_HI  = 7;
    localparam int RY_LO  = 4;
    localparam int RZ_HI  = 3;
    localparam int RZ_LO  = 0;
    function automatic logic is_legal_op(input logic [3:0] op);
        return op < 4'd8;
    endfunction
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction, ALU, result and debug signals of the ALU issue front end
interface alu_issue_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [3:0]  alu_opcode;
    logic [15:0] alu_z;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] result_data;
    logic [3:0]  result_addr;
    logic        result_illegal;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    modport slave (
        input  instr, instr_valid, alu_z, result_ready, dbg_addr,
        output instr_ready, alu_x, alu_y, alu_opcode, result_valid,
               result_data, result_addr, result_illegal, dbg_data
    );
    modport master (
        output instr, instr_valid, alu_z, result_ready, dbg_addr,
        input  instr_ready, alu_x, alu_y, alu_opcode, result_valid,
               result_data, result_addr, result_illegal, dbg_data
    );
endinterface

// File: rtl/alu_issue_regfile.sv
// regfile: 16x16 register file, two operand read ports, debug read port, one write port, r0 reads 0
module regfile (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  i_ra,
    input  logic [3:0]  i_rb,
    input  logic [3:0]  i_rd,
    input  logic        i_we,
    input  logic [3:0]  i_wa,
    input  logic [15:0] i_wd,
    output logic [15:0] o_a,
    output logic [15:0] o_b,
    output logic [15:0] o_d
);
    logic [15:0] r_mem [16];

    // Write port; r0 is never written so it stays at its reset value of 0
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) r_mem[i] <= '0;
        end else if (i_we && i_wa != 4'd0) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    assign o_a = i_ra == 4'd0 ? 16'd0 : r_mem[i_ra];
    assign o_b = i_rb == 4'd0 ? 16'd0 : r_mem[i_rb];
    assign o_d = i_rd == 4'd0 ? 16'd0 : r_mem[i_rd];
endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/write-back front end driving an external combinational ALU
module alu_issue
    import nbbpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    alu_issue_if.slave bus
);
    logic        r_s1_valid;
    logic [3:0]  r_s1_op;
    logic [3:0]  r_s1_rz;
    logic [15:0] r_s1_x;
    logic [15:0] r_s1_y;
    logic        r_out_valid;
    logic [15:0] r_out_data;
    logic [3:0]  r_out_addr;
    logic        r_out_illegal;
    logic        w_advance;
    logic        w_ready;
    logic        w_accept;
    logic        w_complete;
    logic        w_wb;
    logic [3:0]  w_rx;
    logic [3:0]  w_ry;
    logic [15:0] w_rf_a;
    logic [15:0] w_rf_b;
    logic [15:0] w_x;
    logic [15:0] w_y;

    assign w_advance  = !r_out_valid || bus.result_ready;
    assign w_ready    = !r_s1_valid || w_advance;
    assign w_accept   = bus.instr_valid && w_ready;
    assign w_complete = r_s1_valid && w_advance;
    assign w_wb       = w_complete && is_legal_op(r_s1_op) && r_s1_rz != 4'd0;
    assign w_rx       = bus.instr[RX_HI:RX_LO];
    assign w_ry       = bus.instr[RY_HI:RY_LO];
    // A write-back in the accept cycle is not yet in the register file, so bypass alu_z
    assign w_x        = (w_wb && w_rx == r_s1_rz) ? bus.alu_z : w_rf_a;
    assign w_y        = (w_wb && w_ry == r_s1_rz) ? bus.alu_z : w_rf_b;

    regfile u_regfile (
        .clock (clock),
        .reset (reset),
        .i_ra  (w_rx),
        .i_rb  (w_ry),
        .i_rd  (bus.dbg_addr),
        .i_we  (w_wb),
        .i_wa  (r_s1_rz),
        .i_wd  (bus.alu_z),
        .o_a   (w_rf_a),
        .o_b   (w_rf_b),
        .o_d   (bus.dbg_data)
    );

    // Operand stage: load on accept, empty on completion, otherwise hold
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_rz    <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= bus.instr[OPC_HI:OPC_LO];
            r_s1_rz    <= bus.instr[RZ_HI:RZ_LO];
            r_s1_x     <= w_x;
            r_s1_y     <= w_y;
        end else if (w_complete) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Result stage: capture ALU output on completion, drop valid once consumed
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_addr    <= '0;
            r_out_illegal <= 1'b0;
        end else if (w_complete) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= bus.alu_z;
            r_out_addr    <= r_s1_rz;
            r_out_illegal <= !is_legal_op(r_s1_op);
        end else if (bus.result_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign bus.instr_ready    = w_ready;
    assign bus.alu_x          = r_s1_x;
    assign bus.alu_y          = r_s1_y;
    assign bus.alu_opcode     = r_s1_op;
    assign bus.result_valid   = r_out_valid;
    assign bus.result_data    = r_out_data;
    assign bus.result_addr    = r_out_addr;
    assign bus.result_illegal = r_out_illegal;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized and directed stimulus checked against an in-order ISA model
module tb_alu_issue;
    logic clk = 1'b0;
    logic reset = 1'b0;
    alu_issue_if bus ();

    alu_issue dut (.clock(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        case (op)
            4'd0: return x + y;
            4'd1: return x - y;
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return x >> y[3:0];
            4'd6: return x << y[3:0];
            4'd7: return {15'd0, x >= y};
            default: return ~(x ^ y) + {12'd0, op};
        endcase
    endfunction

    always_comb bus.alu_z = alu_f(bus.alu_opcode, bus.alu_x, bus.alu_y);

    function automatic logic [15:0] mk(input int op, input int rz, input int rx, input int ry);
        return {op[3:0], rx[3:0], ry[3:0], rz[3:0]};
    endfunction

    logic [15:0] sq[$];
    int  rdy_mode = 0;
    bit  gaps = 0;
    bit  flush = 0;
    int  n_acc = 0;
    int  seen = 0;
    logic [15:0] cur = '0;
    bit  cur_valid = 0;

    // Driver: offers the next queued instruction once the previous one was accepted
    always @(posedge clk) begin
        #1;
        if (n_acc != seen) begin
            seen = n_acc;
            cur_valid = 0;
        end
        if (flush) cur_valid = 0;
        if (!cur_valid && sq.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
            cur = sq.pop_front();
            cur_valid = 1;
        end
        bus.instr = cur;
        bus.instr_valid = cur_valid;
        bus.result_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'($urandom_range(1));
    end

    logic [15:0] mreg [16];
    logic [20:0] exp_q[$];
    bit prev_acc = 0;
    bit prev_stall = 0;
    logic [3:0]  pa_op;
    logic [15:0] pa_x, pa_y;
    logic [15:0] p_ax, p_ay, p_rd;
    logic [3:0]  p_aop, p_ra;
    logic        p_ri;

    initial for (int i = 0; i < 16; i++) mreg[i] = '0;

    // Checker: the model executes each instruction in order at the moment it is accepted
    always @(negedge clk) begin
        if (!reset) begin
            prev_acc = 0;
            prev_stall = 0;
        end else begin
            if (prev_acc) begin
                chk("alu_opcode", bus.alu_opcode, pa_op);
                chk("alu_x", bus.alu_x, pa_x);
                chk("alu_y", bus.alu_y, pa_y);
            end
            if (prev_stall) begin
                chk("stall_result_data", bus.result_data, p_rd);
                chk("stall_result_addr", bus.result_addr, p_ra);
                chk("stall_result_illegal", bus.result_illegal, p_ri);
                chk("stall_result_valid", bus.result_valid, 1);
                if (!prev_acc) begin
                    chk("stall_alu_x", bus.alu_x, p_ax);
                    chk("stall_alu_y", bus.alu_y, p_ay);
                    chk("stall_alu_opcode", bus.alu_opcode, p_aop);
                end
            end
            if (bus.result_ready) chk("instr_ready_no_drop", bus.instr_ready, 1);
            prev_acc = bus.instr_valid && bus.instr_ready;
            if (prev_acc) begin
                logic [3:0] op, rx, ry, rz;
                logic [15:0] z;
                {op, rx, ry, rz} = bus.instr;
                pa_op = op;
                pa_x = mreg[rx];
                pa_y = mreg[ry];
                z = alu_f(op, pa_x, pa_y);
                if (op < 8 && rz != 0) mreg[rz] = z;
                exp_q.push_back({op >= 4'd8, rz, z});
                n_acc++;
            end
            if (bus.result_valid && bus.result_ready) begin
                if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    logic [20:0] e;
                    e = exp_q.pop_front();
                    chk("result_data", bus.result_data, e[15:0]);
                    chk("result_addr", bus.result_addr, e[19:16]);
                    chk("result_illegal", bus.result_illegal, e[20]);
                end
            end
            prev_stall = bus.result_valid && !bus.result_ready;
            p_ax = bus.alu_x;
            p_ay = bus.alu_y;
            p_aop = bus.alu_opcode;
            p_rd = bus.result_data;
            p_ra = bus.result_addr;
            p_ri = bus.result_illegal;
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while ((sq.size() > 0 || cur_valid || exp_q.size() > 0 || bus.result_valid) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", t >= 500, 0);
        #1;
    endtask

    task automatic dbg_check();
        for (int a = 0; a < 16; a++) begin
            bus.dbg_addr = a[3:0];
            #1;
            chk($sformatf("dbg_r%0d", a), bus.dbg_data, mreg[a]);
        end
    endtask

    initial begin
        bus.instr = '0;
        bus.instr_valid = 0;
        bus.result_ready = 1;
        bus.dbg_addr = 4'd5;
        #2;
        chk("rst_result_valid", bus.result_valid, 0);
        chk("rst_result_data", bus.result_data, 0);
        chk("rst_result_addr", bus.result_addr, 0);
        chk("rst_result_illegal", bus.result_illegal, 0);
        chk("rst_alu_x", bus.alu_x, 0);
        chk("rst_alu_y", bus.alu_y, 0);
        chk("rst_alu_opcode", bus.alu_opcode, 0);
        chk("rst_dbg", bus.dbg_data, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1;
        @(negedge clk);
        chk("instr_ready_after_reset", bus.instr_ready, 1);

        sq.push_back(mk(0, 3, 0, 0));
        drain();
        sq.push_back(mk(7, 8, 0, 0));
        sq.push_back(mk(6, 9, 8, 8));
        sq.push_back(mk(6, 10, 9, 8));
        sq.push_back(mk(3, 1, 10, 8));
        sq.push_back(mk(3, 2, 9, 8));
        sq.push_back(mk(1, 4, 1, 2));
        sq.push_back(mk(0, 5, 1, 2));
        sq.push_back(mk(0, 6, 5, 5));
        drain();
        bus.dbg_addr = 4'd4;
        #1 chk("dbg_r4_sub", bus.dbg_data, 16'h0002);
        bus.dbg_addr = 4'd6;
        #1 chk("dbg_r6_dep", bus.dbg_data, 16'h0010);

        rdy_mode = 1;
        for (int i = 0; i < 4; i++) sq.push_back(mk(i, 11 + i, i + 1, 6 - i));
        repeat (4) @(negedge clk);
        #1 chk("stall_instr_ready", bus.instr_ready, 0);
        rdy_mode = 0;
        drain();

        sq.push_back(mk(10, 7, 1, 2));
        sq.push_back(mk(0, 0, 1, 2));
        drain();
        bus.dbg_addr = 4'd0;
        #1 chk("dbg_r0", bus.dbg_data, 0);
        dbg_check();

        rdy_mode = 2;
        gaps = 1;
        for (int i = 0; i < 200; i++) begin
            int op;
            op = $urandom_range(4) == 0 ? $urandom_range(15) : $urandom_range(7);
            sq.push_back(mk(op, $urandom_range(15), $urandom_range(15), $urandom_range(15)));
        end
        drain();
        rdy_mode = 0;
        gaps = 0;
        dbg_check();

        rdy_mode = 1;
        sq.push_back(mk(0, 1, 2, 3));
        sq.push_back(mk(3, 2, 4, 5));
        sq.push_back(mk(4, 3, 6, 7));
        repeat (5) @(negedge clk);
        chk("pre_reset_result_valid", bus.result_valid, 1);
        @(posedge clk);
        #2 reset = 0;
        flush = 1;
        sq.delete();
        #1 chk("midreset_result_valid", bus.result_valid, 0);
        for (int a = 0; a < 16; a++) begin
            bus.dbg_addr = a[3:0];
            #1 chk($sformatf("midreset_dbg_r%0d", a), bus.dbg_data, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
